// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port flop register file with byte-masked writes,
// per-byte highest-port-wins collision, registered reads and optional write-first bypass.
module regfile_mp #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 64,
    parameter int NUM_READ  = 8,
    parameter int NUM_WRITE = 8,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [NUM_READ-1:0]           rd_en_i,
    input  logic [NUM_READ*AW-1:0]        rd_addr_i,
    output logic [NUM_READ*WIDTH-1:0]     rd_data_o,
    input  logic [NUM_WRITE-1:0]          wr_en_i,
    input  logic [NUM_WRITE*AW-1:0]       wr_addr_i,
    input  logic [NUM_WRITE*WIDTH-1:0]    wr_data_i,
    input  logic [NUM_WRITE*NB-1:0]       wr_mask_i
);
    logic [DEPTH-1:0][NB-1:0][7:0]  mem_q, mem_d;
    logic [NUM_READ-1:0][WIDTH-1:0] rd_q, rd_d;
    logic [AW-1:0]                  ra;
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam bit WR_OK = !(ZERO_REG != 0 && e == 0);
        for (genvar b = 0; b < NB; b++) begin : g_byte
            logic [7:0] nxt;
            // ascending scan: the last matching port, i.e. the highest index, wins
            always_comb begin
                nxt = mem_q[e][b];
                for (int j = 0; j < NUM_WRITE; j++)
                    if (WR_OK && wr_en_i[j] && wr_mask_i[j*NB+b] && wr_addr_i[j*AW +: AW] == AW'(e))
                        nxt = wr_data_i[j*WIDTH+b*8 +: 8];
            end
            assign mem_d[e][b] = nxt;
        end
    end
    always_comb begin
        ra = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_d[i] = rd_q[i];
            if (rd_en_i[i]) begin
                ra = rd_addr_i[i*AW +: AW];
                rd_d[i] = (32'(ra) < DEPTH && !(ZERO_REG != 0 && ra == '0))
                        ? (BYPASS != 0 ? mem_d[ra] : mem_q[ra]) : '0;
            end
        end
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mem_q <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end
    assign rd_data_o = rd_q;
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the mock ALU datapath, generalising the fixed 32x64, 8-read/8-write array.
- Configurable depth, width and port counts.
- Registered reads with per-port enable and hold, optional write-to-read bypass, and deterministic per-byte write-collision priority.
- Optional hardwired-zero entry 0 and synchronous clear of the whole array on reset.

Parameters:
- DEPTH, 32, number of entries; any value >= 2, not restricted to powers of two.
- WIDTH, 64, bits per entry; must be a multiple of 8.
- NUM_READ, 8, number of read ports.
- NUM_WRITE, 8, number of write ports.
- BYPASS, 1, 1 = write-first (same-cycle write data visible on read); 0 = read-first.
- ZERO_REG, 0, 1 = entry 0 always reads zero and ignores writes.
- Derived: AW = $clog2(DEPTH); NB = WIDTH/8.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd_en  in  NUM_READ  per-port read enable.
- rd_addr  in  NUM_READ*AW  read addresses; port i uses slice [i*AW +: AW].
- rd_data  out  NUM_READ*WIDTH  registered read data; port i uses slice [i*WIDTH +: WIDTH].
- wr_en  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*AW  write addresses.
- wr_data  in  NUM_WRITE*WIDTH  write data.
- wr_mask  in  NUM_WRITE*NB  byte enables; bit b covers data bits [8b+7:8b].

Behaviour:
- Reset (reset=1 at a clock edge):
  - All DEPTH entries and all rd_data cleared to 0 in that same edge.
  - Writes and reads presented in a reset cycle are ignored.
  - First usable cycle is the one after reset deasserts.
  - Reset asserted mid-stream discards any in-flight read result; rd_data is 0 on the following cycle.
- Write:
  - At an edge with wr_en[j]=1 and a valid address, each byte b with wr_mask[j][b]=1 updates.
  - Unmasked bytes keep their value.
  - wr_en=1 with an all-zero mask is a no-op.
- Write collision: several ports hitting the same address and byte in one cycle resolve per byte; the highest port index wins. Example: port 7 beats port 0. Non-overlapping bytes from different ports all land.
- Read latency: 1 cycle.
  - rd_en[i]=1 at edge t samples rd_addr[i]; rd_data[i] shows the result from t+1 onward.
  - rd_en[i]=0: rd_data[i] holds its last value indefinitely.
- BYPASS=1: a read at edge t returns the merged post-write value of that entry, with same-cycle writes applied using the same collision rule. There is no combinational path from any input to rd_data.
- BYPASS=0: a read at edge t returns the entry value before the edge-t writes.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH is not a power of 2):
  - Write is dropped.
  - Read returns 0.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
- Multiple read ports may read the same address in the same cycle; all receive identical data.
- Storage is flops, no memory macro. The implementation is a generate loop over entries × bytes with a priority-encoded write select per byte.

Test Plan:
- Reset clear: write 0xFFFF_FFFF_FFFF_FFFF to all 32 entries, assert reset 1 cycle, then read all entries on 8 ports -> every rd_data = 0; a write presented during reset is not stored.
- Byte mask: write 0x1122334455667788 to addr 5 with mask 0xFF, then write 0xAAAAAAAAAAAAAAAA with mask 0x0F, read addr 5 -> 0x11223344AAAAAAAA one cycle after rd_en.
- Collision priority: same cycle, port 0 writes addr 3 = 0x0101..01 mask 0xFF and port 7 writes addr 3 = 0x0202..02 mask 0x03 -> addr 3 reads 0x010101010101_0202.
- Bypass: BYPASS=1, write addr 9 = 0xDEAD and read addr 9 on the same edge -> rd_data = 0xDEAD next cycle. BYPASS=0, same stimulus -> prior value 0, then 0xDEAD on a repeat read.
- Hold and zero register: ZERO_REG=1, write addr 0 = 0x1234, read addr 0 -> 0. Then drop rd_en for 5 cycles while changing rd_addr -> rd_data unchanged.
- Non-power-of-2 depth: DEPTH=20, write addr 25 = 0x55, read addr 25 -> 0; entries 0..19 unaffected.
